interfaz_uart_alu: RTL
======================

INTERFAZ_UART_ALU -- requirements
Module: interfaz_uart_alu

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16: width of operands A, B and of the ALU result; must be an integer multiple of TRAMA_SIZE.
REQ-002 SHALL have parameter TRAMA_SIZE, default 8: width of one UART byte (RX and TX).
REQ-003 SHALL have parameter OPCODE_SIZE, default 6: opcode width; must be <= TRAMA_SIZE.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout in clocks; 0 disables the timeout.
REQ-005 SHALL derive NB_BYTES = DATA_SIZE/TRAMA_SIZE bytes per operand and per result.
REQ-006 i_clk  input  1  single clock; all state changes on rising edge.
REQ-007 i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 i_rx_data  input  TRAMA_SIZE  byte from the UART receiver, valid when i_rx_done = 1.
REQ-009 i_rx_done  input  1  one-cycle strobe: a new RX byte is present.
REQ-010 o_a, o_b  output  DATA_SIZE each  ALU operands from the last complete frame.
REQ-011 o_opcode  output  OPCODE_SIZE  ALU opcode from the last complete frame.
REQ-012 o_alu_valid  output  1  one-cycle pulse: operands and opcode are fresh; the result is sampled this cycle.
REQ-013 i_alu_result  input  DATA_SIZE  combinational ALU result.
REQ-014 o_tx_data  output  TRAMA_SIZE  byte to the UART transmitter.
REQ-015 o_tx_start  output  1  one-cycle strobe: the transmitter shall send o_tx_data.
REQ-016 i_tx_done  input  1  one-cycle strobe: the transmitter finished the current byte.
REQ-017 o_busy  output  1  high in states EXEC and TX.
REQ-018 o_timeout_err  output  1  one-cycle pulse: a partial frame was discarded by timeout.

Function
REQ-019 SHALL implement FSM states IDLE, RX_A, RX_B, RX_OP, EXEC, TX.
REQ-020 Frame order SHALL be: NB_BYTES of A (LSB first), then NB_BYTES of B (LSB first), then 1 opcode byte (low OPCODE_SIZE bits used, remaining bits ignored).
REQ-021 Transitions: IDLE->RX_A on the first i_rx_done; RX_A->RX_B after the NB_BYTES-th A byte; RX_B->RX_OP after the NB_BYTES-th B byte; RX_OP->EXEC on the opcode byte; EXEC->TX unconditionally after 1 cycle; TX->IDLE after i_tx_done for the last byte.
REQ-022 If NB_BYTES = 1, the first byte SHALL complete A and the FSM SHALL go IDLE->RX_B directly.
REQ-023 Incoming bytes SHALL accumulate in internal shadow registers; o_a, o_b and o_opcode SHALL update only on the opcode-byte cycle, and SHALL hold their values otherwise.
REQ-024 Latency: opcode byte strobe at cycle N -> new o_a/o_b/o_opcode and o_alu_valid = 1 in cycle N+1; i_alu_result captured at the end of N+1; o_tx_start = 1 with o_tx_data = result[TRAMA_SIZE-1:0] in cycle N+2.
REQ-025 TX: after i_tx_done at cycle M for byte k < NB_BYTES-1, o_tx_start SHALL pulse at M+1 with byte k+1; after the last byte, the FSM SHALL be in IDLE at M+1.
REQ-026 o_tx_data SHALL hold the current byte from its o_tx_start cycle until the matching i_tx_done.
REQ-027 i_rx_done in EXEC or TX SHALL be ignored (byte dropped); i_tx_done outside TX SHALL be ignored.
REQ-028 The timeout counter SHALL clear on each accepted byte and count only in RX_A/RX_B/RX_OP; on reaching TIMEOUT_CYCLES it SHALL clear the shadow registers, return to IDLE and pulse o_timeout_err for 1 cycle.
REQ-029 If i_rx_done and timeout expiry coincide, the byte SHALL be accepted and no timeout SHALL occur.
REQ-030 The byte counter SHALL be sized ceil(log2(NB_BYTES+1)) bits and SHALL reset to 0 at every state change; it SHALL never wrap.

Reset
REQ-031 i_reset = 0 SHALL immediately force state IDLE and clear all counters and shadow registers.
REQ-032 During reset, outputs SHALL be o_a = o_b = 0, o_opcode = 0, o_tx_data = 0, and o_alu_valid = o_tx_start = o_busy = o_timeout_err = 0.
REQ-033 Reset asserted mid-frame or mid-TX SHALL abort the operation with no further strobes; deassertion SHALL leave the block in IDLE.

Verification (DATA_SIZE=16, TRAMA_SIZE=8, OPCODE_SIZE=6)
REQ-034 RX 0x34,0x12,0x78,0x56,0x20; ALU returns 0x68AC -> o_a=0x1234, o_b=0x5678, o_opcode=0x20, one o_alu_valid pulse; TX sends 0xAC then 0x68, then IDLE.
REQ-035 Opcode byte 0xE5 -> o_opcode=0x25.
REQ-036 TIMEOUT_CYCLES=50; 3 bytes then silence -> o_timeout_err pulse after 50 idle cycles; the next 5 bytes form a clean frame.
REQ-037 Extra RX bytes during TX -> dropped; outputs unchanged; the next frame decodes correctly.
REQ-038 Reset asserted after 2 TX strobes in flight -> all outputs 0, no o_tx_start after release.
REQ-039 i_rx_done coincident with timeout expiry -> byte accepted, no o_timeout_err.

Source files
------------

// File: rtl/interfaz_uart_alu_if.sv
// -----------------------------------------------------------------------------
// interfaz_uart_alu_if
// Bundles the three streams the UART<->ALU frame controller talks to:
//   RX  : i_rx_data / i_rx_done       (byte from the UART receiver)
//   ALU : o_a / o_b / o_opcode / o_alu_valid / i_alu_result
//   TX  : o_tx_data / o_tx_start / i_tx_done (byte to the UART transmitter)
//   status: o_busy, o_timeout_err
// Signal names keep the controller's point of view (i_ = into the controller).
// Modports:
//   slave  - the frame controller (interfaz_uart_alu)
//   master - the environment around it (UART RX/TX, ALU, testbench)
// -----------------------------------------------------------------------------
interface interfaz_uart_alu_if #(
  parameter int DATA_SIZE   = 16,
  parameter int TRAMA_SIZE  = 8,
  parameter int OPCODE_SIZE = 6
);
  logic [TRAMA_SIZE-1:0]  i_rx_data;
  logic                   i_rx_done;
  logic [DATA_SIZE-1:0]   o_a;
  logic [DATA_SIZE-1:0]   o_b;
  logic [OPCODE_SIZE-1:0] o_opcode;
  logic                   o_alu_valid;
  logic [DATA_SIZE-1:0]   i_alu_result;
  logic [TRAMA_SIZE-1:0]  o_tx_data;
  logic                   o_tx_start;
  logic                   i_tx_done;
  logic                   o_busy;
  logic                   o_timeout_err;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_a, o_b, o_opcode, o_alu_valid, o_tx_data, o_tx_start,
           o_busy, o_timeout_err
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_a, o_b, o_opcode, o_alu_valid, o_tx_data, o_tx_start,
           o_busy, o_timeout_err
  );
endinterface

// File: rtl/interfaz_uart_alu.sv
// -----------------------------------------------------------------------------
// interfaz_uart_alu
// Frame controller between a byte UART and a combinational ALU.
// A frame is NB_BYTES of A (LSB first), NB_BYTES of B (LSB first) and one
// opcode byte. When the opcode byte arrives the operands are published for one
// cycle (o_alu_valid), the ALU result is captured, and it is sent back LSB first
// one byte per o_tx_start / i_tx_done handshake.
// A partial frame followed by TIMEOUT_CYCLES silent cycles is discarded.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous reset, active low
//   bus      - interfaz_uart_alu_if.slave (RX, ALU and TX streams + status)
// -----------------------------------------------------------------------------
module interfaz_uart_alu #(
  parameter int DATA_SIZE      = 16,
  parameter int TRAMA_SIZE     = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  interfaz_uart_alu_if.slave    bus
);

  localparam int NB_BYTES = DATA_SIZE / TRAMA_SIZE;
  localparam int CNT_W    = $clog2(NB_BYTES + 1);
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMR_EN   = (TIMEOUT_CYCLES > 0);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NB_BYTES - 1);
  // In RX_A the counter lags the byte index by one: byte 0 is taken in IDLE.
  localparam logic [CNT_W-1:0] CNT_LAST_A = CNT_W'((NB_BYTES > 1) ? NB_BYTES - 2 : 0);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, RX_A, RX_B, RX_OP, EXEC, TX} state_t;
  typedef logic [NB_BYTES-1:0][TRAMA_SIZE-1:0] word_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMR_W-1:0]       tmr_q;
  word_t                  sh_a_q, sh_b_q, res_q;
  logic [DATA_SIZE-1:0]   a_q, b_q;
  logic [OPCODE_SIZE-1:0] op_q;
  logic [TRAMA_SIZE-1:0]  tx_data_q;
  logic                   tx_start_q;
  logic                   timeout_err_q;

  logic                   in_rx;
  logic                   accept;
  logic                   tmr_expire;
  logic [IDX_W-1:0]       rx_idx;
  logic [IDX_W-1:0]       tx_idx;

  assign in_rx  = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
  // Bytes are only taken while a frame is being received; EXEC/TX drop them.
  assign accept = bus.i_rx_done && (in_rx || (state_q == IDLE));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, byte counter and byte-lane selects
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_expire = 1'b0;
    rx_idx     = '0;
    tx_idx     = IDX_W'(cnt_q + CNT_ONE);

    unique case (state_q)
      IDLE: begin
        if (bus.i_rx_done) state_d = (NB_BYTES == 1) ? RX_B : RX_A;
      end
      RX_A: begin
        rx_idx = IDX_W'(cnt_q + CNT_ONE);
        if (bus.i_rx_done) begin
          if (cnt_q == CNT_LAST_A) state_d = RX_B;
          else                     cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RX_B: begin
        rx_idx = IDX_W'(cnt_q);
        if (bus.i_rx_done) begin
          if (cnt_q == CNT_LAST) state_d = RX_OP;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RX_OP: begin
        if (bus.i_rx_done) state_d = EXEC;
      end
      EXEC: begin
        state_d = TX;
      end
      TX: begin
        if (bus.i_tx_done) begin
          if (cnt_q == CNT_LAST) state_d = IDLE;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Silence timeout. A byte arriving in the expiry cycle wins over it.
    if (TMR_EN && in_rx && !bus.i_rx_done && (tmr_q == TMR_LAST)) begin
      state_d    = IDLE;
      tmr_expire = 1'b1;
    end

    // The counter is per-state, so any transition restarts it.
    if (state_d != state_q) cnt_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timer: counts silent cycles inside a partial frame only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmr_q <= '0;
    end else if (!TMR_EN || accept || !in_rx || tmr_expire) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shadow accumulation, operand publish, result capture, TX bytes
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset too: the outputs must read zero during
  // reset and an aborted frame must not leave stale bytes behind.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sh_a_q        <= '0;
      sh_b_q        <= '0;
      res_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      timeout_err_q <= tmr_expire;

      if (tmr_expire) begin
        sh_a_q <= '0;
        sh_b_q <= '0;
      end else if (bus.i_rx_done) begin
        case (state_q)
          IDLE, RX_A: sh_a_q[rx_idx] <= bus.i_rx_data;
          RX_B:       sh_b_q[rx_idx] <= bus.i_rx_data;
          RX_OP: begin
            // Operands change only here, so the ALU never sees a half frame.
            a_q  <= sh_a_q;
            b_q  <= sh_b_q;
            op_q <= bus.i_rx_data[OPCODE_SIZE-1:0];
          end
          default: ;
        endcase
      end

      if (state_q == EXEC) begin
        res_q      <= bus.i_alu_result;
        tx_data_q  <= bus.i_alu_result[TRAMA_SIZE-1:0];
        tx_start_q <= 1'b1;
      end else if ((state_q == TX) && bus.i_tx_done && (cnt_q != CNT_LAST)) begin
        tx_data_q  <= res_q[tx_idx];
        tx_start_q <= 1'b1;
      end
    end
  end

  assign bus.o_a           = a_q;
  assign bus.o_b           = b_q;
  assign bus.o_opcode      = op_q;
  assign bus.o_alu_valid   = (state_q == EXEC);
  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_tx_start    = tx_start_q;
  assign bus.o_busy        = (state_q == EXEC) || (state_q == TX);
  assign bus.o_timeout_err = timeout_err_q;

endmodule
